// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler that time-shares a 31-input mux and hands data downstream.
// Optional MUX_SCHED_BURST_EN allows up to BURST_MAX back-to-back transfers per grant.
module mux_rr_scheduler #(
    parameter int NUM_CH = 31,
    parameter int DATA_W = 2
`ifdef MUX_SCHED_BURST_EN
    ,
    parameter int BURST_MAX = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [4:0]        mux_sel,
    input  logic [DATA_W-1:0] mux_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [4:0]        out_ch,
    output logic [NUM_CH-1:0] gnt,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SEL, HOLD} state_e;

    state_e            state_q, state_d;
    logic [4:0]        ptr_q, ptr_d;
    logic [4:0]        sel_q, sel_d;
    logic [4:0]        ch_q, ch_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              pick_found;
    logic [4:0]        pick_ch;
    logic [4:0]        pick_code;
    logic [4:0]        ptr_next;
    logic              burst_go;
`ifdef MUX_SCHED_BURST_EN
    logic [2:0]        burst_q, burst_d;
`endif

    // First requester at or after ptr, wrapping at NUM_CH.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_ch    = 5'(idx);
            end
        end
    end

    // Channel 30 maps to 11111; code 11110 would read back zero.
    assign pick_code = (pick_ch == 5'd30) ? 5'b11111 : pick_ch;
    assign ptr_next  = (ch_q == 5'd30) ? 5'd0 : ch_q + 5'd1;

`ifdef MUX_SCHED_BURST_EN
    assign burst_go = req[ch_q] && (int'(burst_q) < BURST_MAX);
`else
    assign burst_go = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        data_d  = data_q;
        gnt_d   = '0;
`ifdef MUX_SCHED_BURST_EN
        burst_d = burst_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    ch_d    = pick_ch;
                    sel_d   = pick_code;
                    state_d = SEL;
`ifdef MUX_SCHED_BURST_EN
                    burst_d = 3'd1;
`endif
                end
            end
            SEL: begin
                data_d  = mux_out;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    gnt_d   = NUM_CH'(1) << ch_q;
                    valid_d = 1'b0;
                    if (burst_go) begin
                        state_d = SEL;
`ifdef MUX_SCHED_BURST_EN
                        burst_d = (burst_q == 3'd7) ? 3'd7 : burst_q + 3'd1;
`endif
                    end else begin
                        ptr_d   = ptr_next;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef MUX_SCHED_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) burst_q <= 3'd0;
        else        burst_q <= burst_d;
    end
`endif

    assign mux_sel   = sel_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);

endmodule
